// File: rtl/bar_ram_scheduler.sv
// Single-port arbiter for the bar-height RAM: VGA reads > per-frame decay sweep > producer writes.
// Optional build macro PEAK_HOLD_EN turns producer writes into read-modify-write max(old, new).
module bar_ram_scheduler #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int NUM_BINS = 32,
    parameter int DECAY    = 1
) (
    input  logic              cclk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_bin,
    input  logic [DATA_W-1:0] wr_mag,
    output logic              wr_ready,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, DEC_RD, DEC_WR, PK_RD, PK_WR} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);
    localparam logic [DATA_W-1:0] DECAY_V  = DATA_W'(DECAY);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              tick_pend_reg, tick_pend_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic              first_reg, first_next;
    logic              vga_valid_reg;
`ifdef PEAK_HOLD_EN
    logic [ADDR_W-1:0] pk_bin_reg, pk_bin_next;
    logic [DATA_W-1:0] pk_mag_reg, pk_mag_next;
    logic [DATA_W-1:0] pk_new;
`endif

    logic              tick_seen;
    logic              wr_accept;
    logic [DATA_W-1:0] old_val;
    logic [DATA_W-1:0] decayed;

    assign tick_seen = frame_tick | tick_pend_reg;
    assign wr_ready  = !reset && !vga_rd_req && (state_reg == IDLE) && !tick_seen;
    assign wr_accept = wr_valid & wr_ready;
    assign busy      = (state_reg == DEC_RD) || (state_reg == DEC_WR);

    // The RMW read lands on ram_rdata only in the first write-phase cycle;
    // any later (stalled) cycle must use the captured copy, since VGA reads
    // overwrite ram_rdata in between.
    assign old_val = first_reg ? ram_rdata : hold_reg;
    assign decayed = (old_val >= DECAY_V) ? (old_val - DECAY_V) : '0;
`ifdef PEAK_HOLD_EN
    assign pk_new  = (old_val > pk_mag_reg) ? old_val : pk_mag_reg;
`endif

    assign vga_rd_valid = vga_valid_reg;
    assign vga_rd_data  = vga_valid_reg ? ram_rdata : '0;

    always_ff @(posedge cclk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            tick_pend_reg <= 1'b0;
            hold_reg      <= '0;
            first_reg     <= 1'b0;
            vga_valid_reg <= 1'b0;
`ifdef PEAK_HOLD_EN
            pk_bin_reg    <= '0;
            pk_mag_reg    <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            tick_pend_reg <= tick_pend_next;
            hold_reg      <= hold_next;
            first_reg     <= first_next;
            vga_valid_reg <= vga_rd_req;
`ifdef PEAK_HOLD_EN
            pk_bin_reg    <= pk_bin_next;
            pk_mag_reg    <= pk_mag_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        tick_pend_next = tick_pend_reg;
        hold_next      = hold_reg;
        first_next     = 1'b0;
`ifdef PEAK_HOLD_EN
        pk_bin_next    = pk_bin_reg;
        pk_mag_next    = pk_mag_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (tick_seen && !vga_rd_req) begin
                    state_next     = DEC_RD;
                    idx_next       = '0;
                    tick_pend_next = 1'b0;
                end else begin
                    // A tick blocked by a VGA read is remembered, not lost.
                    if (frame_tick) tick_pend_next = 1'b1;
`ifdef PEAK_HOLD_EN
                    if (wr_accept) begin
                        pk_bin_next = wr_bin;
                        pk_mag_next = wr_mag;
                        state_next  = PK_RD;
                    end
`endif
                end
            end
            DEC_RD: begin
                if (!vga_rd_req) begin
                    state_next = DEC_WR;
                    first_next = 1'b1;
                end
            end
            DEC_WR: begin
                if (first_reg) hold_next = ram_rdata;
                if (!vga_rd_req) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = DEC_RD;
                    end
                end
            end
`ifdef PEAK_HOLD_EN
            PK_RD: begin
                if (frame_tick) tick_pend_next = 1'b1;
                if (!vga_rd_req) begin
                    state_next = PK_WR;
                    first_next = 1'b1;
                end
            end
            PK_WR: begin
                if (frame_tick) tick_pend_next = 1'b1;
                if (first_reg) hold_next = ram_rdata;
                if (!vga_rd_req) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (reset) begin
            ram_en = 1'b0;
        end else if (vga_rd_req) begin
            ram_en   = 1'b1;
            ram_addr = vga_rd_addr;
        end else begin
            case (state_reg)
                IDLE: begin
`ifndef PEAK_HOLD_EN
                    if (wr_accept) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = wr_bin;
                        ram_wdata = wr_mag;
                    end
`endif
                end
                DEC_RD: begin
                    ram_en   = 1'b1;
                    ram_addr = idx_reg;
                end
                DEC_WR: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = idx_reg;
                    ram_wdata = decayed;
                end
`ifdef PEAK_HOLD_EN
                PK_RD: begin
                    ram_en   = 1'b1;
                    ram_addr = pk_bin_reg;
                end
                PK_WR: begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = pk_bin_reg;
                    ram_wdata = pk_new;
                end
`endif
                default: ram_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_ram_scheduler.sv
// Self-checking bench for bar_ram_scheduler: table vectors, directed sweep/reset sequences and
// a randomized phase against a bar-height array model. Holds a behavioural single-port RAM.
module tb_bar_ram_scheduler;

`ifdef PEAK_HOLD_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic       cclk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       vga_rd_req;
    logic [4:0] vga_rd_addr;
    logic       vga_rd_valid;
    logic [7:0] vga_rd_data;
    logic       wr_valid;
    logic [4:0] wr_bin;
    logic [7:0] wr_mag;
    logic       wr_ready;
    logic       busy;
    logic       ram_en;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [7:0] mem   [32];
    logic [7:0] model [32];
    logic       bd_load = 1'b0;

    always #5 cclk = ~cclk;

    bar_ram_scheduler #(.ADDR_W(5), .DATA_W(8), .NUM_BINS(32), .DECAY(1)) dut (
        .cclk(cclk), .reset(reset), .frame_tick(frame_tick),
        .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
        .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
        .wr_valid(wr_valid), .wr_bin(wr_bin), .wr_mag(wr_mag),
        .wr_ready(wr_ready), .busy(busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM; bd_load copies the model image in as a backdoor preload.
    always @(posedge cclk) begin
        if (bd_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= model[i];
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
        if (ram_en && ram_we) wr_cnt <= wr_cnt + 1;
    end

    typedef struct packed {
        logic       req;
        logic [4:0] raddr;
        logic       wv;
        logic [4:0] bin;
        logic [7:0] mag;
        logic       exp_ready;
        logic       exp_en;
        logic       exp_we;
        logic [4:0] exp_addr;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] wr_rule(input logic [7:0] old, input logic [7:0] mag);
        if (PK) return (old > mag) ? old : mag;
        return mag;
    endfunction

    task automatic load_model();
        @(negedge cclk); bd_load = 1'b1;
        @(negedge cclk); bd_load = 1'b0;
    endtask

    task automatic compare_mem(input string nm);
        int bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== model[i]) bad++;
        chk({nm, "_bins_wrong"}, bad, 0);
    endtask

    task automatic decay_model();
        for (int i = 0; i < 32; i++) model[i] = (model[i] > 8'd1) ? model[i] - 8'd1 : 8'd0;
    endtask

    task automatic do_write(input string nm, input logic [4:0] b, input logic [7:0] m);
        int n = 0;
        @(negedge cclk); wr_valid = 1'b1; wr_bin = b; wr_mag = m; #1;
        while (!wr_ready && n < 200) begin @(negedge cclk); #1; n++; end
        chk({nm, "_accept_timeout"}, (n < 200), 1);
        @(negedge cclk); wr_valid = 1'b0;
        model[b] = wr_rule(model[b], m);
        repeat (4) @(negedge cclk);
    endtask

    task automatic vga_read(input string nm, input logic [4:0] a, input logic [7:0] e);
        @(negedge cclk); vga_rd_req = 1'b1; vga_rd_addr = a; #1;
        chk({nm, "_ram_en"}, ram_en, 1);
        chk({nm, "_ram_we"}, ram_we, 0);
        chk({nm, "_ram_addr"}, ram_addr, a);
        @(negedge cclk); vga_rd_req = 1'b0; #1;
        chk({nm, "_valid"}, vga_rd_valid, 1);
        chk({nm, "_data"}, vga_rd_data, e);
    endtask

    // Pulses frame_tick, counts busy cycles; VGA reads in window [vs, vs+vl)
    // target bin 0 (already decayed, 10->9) or bins 20..29 (not yet reached, 10).
    task automatic sweep_run(input string nm, input int vs, input int vl, output int bc);
        logic       pr = 1'b0;
        logic [7:0] pe = '0;
        bit         done = 1'b0;
        bc = 0;
        @(negedge cclk); frame_tick = 1'b1;
        @(negedge cclk); frame_tick = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (pr) begin
                chk({nm, "_rd_valid"}, vga_rd_valid, 1);
                chk({nm, "_rd_data"}, vga_rd_data, pe);
            end
            if (busy) bc++; else done = 1'b1;
            pr = (c >= vs) && (c < vs + vl) && !done;
            vga_rd_req  = pr;
            vga_rd_addr = c[0] ? 5'd0 : 5'(20 + c % 10);
            pe          = c[0] ? 8'd9 : 8'd10;
            if (!done) @(negedge cclk);
        end
        vga_rd_req = 1'b0;
        chk({nm, "_timeout"}, done, 1);
    endtask

    initial begin
        int bc, n, wc;
        logic [7:0] exp_rd;
        logic       pr;
        logic [7:0] pe;

        vt[0] = '{1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1'b0, 5'd0,  8'h00};
        vt[1] = '{1'b0, 5'd0,  1'b1, 5'd3,  8'h40, 1'b1, !PK,  !PK,  5'd3,  8'h40};
        vt[2] = '{1'b1, 5'd7,  1'b1, 5'd9,  8'h11, 1'b0, 1'b1, 1'b0, 5'd7,  8'h00};
        vt[3] = '{1'b1, 5'd31, 1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0, 5'd31, 8'h00};
        vt[4] = '{1'b0, 5'd0,  1'b1, 5'd31, 8'hFF, 1'b1, !PK,  !PK,  5'd31, 8'hFF};

        reset = 1'b1; frame_tick = 1'b0; vga_rd_req = 1'b0; vga_rd_addr = '0;
        wr_valid = 1'b0; wr_bin = '0; wr_mag = '0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        repeat (2) @(negedge cclk);
        #1;
        chk("rst_valid", vga_rd_valid, 0);
        chk("rst_data", vga_rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        @(negedge cclk); reset = 1'b0;
        load_model();

        // Table of single-cycle IDLE behaviours.
        for (int i = 0; i < 5; i++) begin
            @(negedge cclk);
            vga_rd_req = vt[i].req; vga_rd_addr = vt[i].raddr;
            wr_valid = vt[i].wv; wr_bin = vt[i].bin; wr_mag = vt[i].mag;
            #1;
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, vt[i].exp_ready);
            chk($sformatf("vec%0d_ram_en", i), ram_en, vt[i].exp_en);
            chk($sformatf("vec%0d_ram_we", i), ram_we, vt[i].exp_we);
            if (vt[i].exp_en) chk($sformatf("vec%0d_ram_addr", i), ram_addr, vt[i].exp_addr);
            if (vt[i].exp_we) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vt[i].exp_wdata);
            exp_rd = model[vt[i].raddr];
            if (vt[i].wv && vt[i].exp_ready) model[vt[i].bin] = wr_rule(model[vt[i].bin], vt[i].mag);
            @(negedge cclk);
            vga_rd_req = 1'b0; wr_valid = 1'b0; #1;
            chk($sformatf("vec%0d_rd_valid", i), vga_rd_valid, vt[i].req);
            if (vt[i].req) chk($sformatf("vec%0d_rd_data", i), vga_rd_data, exp_rd);
            repeat (3) @(negedge cclk);
        end
        vga_read("t2_read_bin3", 5'd3, 8'h40);
        compare_mem("table");

        // Peak-hold versus overwrite on bin 7.
        model[7] = 8'h50; load_model();
        do_write("t6_w30", 5'd7, 8'h30);
        vga_read("t6_read1", 5'd7, PK ? 8'h50 : 8'h30);
        do_write("t6_w90", 5'd7, 8'h90);
        vga_read("t6_read2", 5'd7, 8'h90);

        // Full sweep, no VGA traffic; zero bins must not wrap.
        for (int i = 0; i < 32; i++) model[i] = 8'd5;
        model[0] = 8'd0; model[17] = 8'd0;
        load_model();
        sweep_run("t3", 0, 0, bc);
        chk("t3_busy_cycles", bc, 64);
        decay_model();
        compare_mem("t3");
        vga_read("t3_read_bin17", 5'd17, 8'd0);
        vga_read("t3_read_bin5", 5'd5, 8'd4);

        // Sweep with 10 cycles of VGA reads starting on a write-phase cycle.
        for (int i = 0; i < 32; i++) model[i] = 8'd10;
        load_model();
        sweep_run("t4", 11, 10, bc);
        chk("t4_busy_cycles", bc, 74);
        decay_model();
        compare_mem("t4");

        // Tick and write offered in the same IDLE cycle.
        for (int i = 0; i < 32; i++) model[i] = 8'd6;
        load_model();
        @(negedge cclk);
        frame_tick = 1'b1; wr_valid = 1'b1; wr_bin = 5'd5; wr_mag = 8'h77; #1;
        chk("t5_ready_on_tick", wr_ready, 0);
        chk("t5_no_write_on_tick", ram_we, 0);
        @(negedge cclk); frame_tick = 1'b0; n = 1; #1;
        while (!wr_ready && n < 200) begin @(negedge cclk); #1; n++; end
        chk("t5_ready_low_cycles", n, 65);
        chk("t5_busy_at_accept", busy, 0);
        @(negedge cclk); wr_valid = 1'b0;
        decay_model();
        model[5] = wr_rule(model[5], 8'h77);
        repeat (4) @(negedge cclk);
        compare_mem("t5");

        // Reset held two cycles in the middle of a sweep.
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        load_model();
        @(negedge cclk); frame_tick = 1'b1;
        @(negedge cclk); frame_tick = 1'b0;
        repeat (8) @(negedge cclk);
        reset = 1'b1;
        @(negedge cclk); #1;
        chk("t1_busy_in_reset", busy, 0);
        chk("t1_ram_en_in_reset", ram_en, 0);
        chk("t1_wr_ready_in_reset", wr_ready, 0);
        @(negedge cclk); reset = 1'b0; #1;
        chk("t1_busy_after", busy, 0);
        chk("t1_valid_after", vga_rd_valid, 0);
        chk("t1_data_after", vga_rd_data, 0);
        chk("t1_ram_we_after", ram_we, 0);
        chk("t1_ram_en_after", ram_en, 0);
        wc = wr_cnt;
        repeat (80) @(negedge cclk);
        chk("t1_writes_after_reset", wr_cnt - wc, 0);
        chk("t1_bin0_decayed", mem[0], 8'h1F);
        chk("t1_bin31_untouched", mem[31], 8'h20);

`ifndef PEAK_HOLD_EN
        // Random VGA reads and producer writes in IDLE against the array model.
        for (int i = 0; i < 32; i++) model[i] = 8'($urandom);
        load_model();
        pr = 1'b0; pe = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge cclk); #1;
            if (pr) chk("rnd_rd_data", vga_rd_data, pe);
            chk("rnd_rd_valid", vga_rd_valid, pr);
            vga_rd_req  = ($urandom_range(0, 2) == 0);
            vga_rd_addr = 5'($urandom);
            wr_valid    = 1'($urandom_range(0, 1));
            wr_bin      = 5'($urandom);
            wr_mag      = 8'($urandom);
            #1;
            chk("rnd_wr_ready", wr_ready, !vga_rd_req);
            if (vga_rd_req) pe = model[vga_rd_addr];
            else if (wr_valid) model[wr_bin] = wr_mag;
            pr = vga_rd_req;
        end
        @(negedge cclk); vga_rd_req = 1'b0; wr_valid = 1'b0; #1;
        if (pr) chk("rnd_last_rd_data", vga_rd_data, pe);
        repeat (2) @(negedge cclk);
        compare_mem("rnd");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
